// File: rtl/engine_sched_pkg.sv
// Shared types and default sizing for the pixel-engine scheduler.
// Nothing here holds state; it only fixes the FSM encoding and the default parameters.
package engine_sched_pkg;

    localparam int DEF_NUM_REQ       = 4;
    localparam int DEF_START_TIMEOUT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

endpackage

// File: rtl/engine_scheduler_if.sv
// Requester and engine handshake bundle between the scheduler and its neighbours.
// slave = scheduler side, master = requesters/engine/observer side.
interface engine_scheduler_if
    import engine_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] req_extra;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic               eng_start;
    logic               eng_extra_at_start;
    logic               eng_idle;
    logic               busy;
    logic               start_err;
    logic [15:0]        frame_count;

    modport slave (
        input  req, req_extra, eng_idle,
        output grant, done, eng_start, eng_extra_at_start, busy, start_err, frame_count
    );

    modport master (
        output req, req_extra, eng_idle,
        input  grant, done, eng_start, eng_extra_at_start, busy, start_err, frame_count
    );

endinterface

// File: rtl/engine_scheduler_rr_arbiter.sv
// Round-robin pick: searches upward from last_winner+1 (mod NUM_REQ), purely combinational.
// valid is low when no request bit is set; winner is then zero.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_winner,
    output logic [NUM_REQ-1:0]         winner,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx,
    output logic                       valid
);

    localparam int IDXW = $clog2(NUM_REQ);

    int              k;
    logic [IDXW-1:0] kk;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        k          = 0;
        kk         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k  = (int'(last_winner) + i) % NUM_REQ;
            kk = IDXW'(k);
            if (!valid && req[kk]) begin
                valid      = 1'b1;
                winner[kk] = 1'b1;
                winner_idx = kk;
            end
        end
    end

endmodule

// File: rtl/engine_scheduler.sv
// Shares one pixel engine among NUM_REQ level requesters; grant+start 1 cycle after request, done 1 cycle after engine idle.
// Requests are only sampled in S_IDLE with the engine idle; a missing engine response times out into start_err.
module engine_scheduler
    import engine_sched_pkg::*;
#(
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    engine_scheduler_if.slave  sif
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int TW   = $clog2(START_TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic [IDXW-1:0]    owner_q, owner_nxt;
    logic [IDXW-1:0]    last_q, last_nxt;
    logic               extra_q, extra_nxt;
    logic [TW-1:0]      tmr_q, tmr_nxt;
    logic               err_q, err_nxt;
    logic [15:0]        frame_cnt, frame_cnt_nxt;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDXW-1:0]    win_idx;
    logic               win_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (sif.req),
        .last_winner (last_q),
        .winner      (win_oh),
        .winner_idx  (win_idx),
        .valid       (win_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= IDXW'(NUM_REQ - 1);
            extra_q   <= 1'b0;
            tmr_q     <= '0;
            err_q     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant_q   <= grant_nxt;
            owner_q   <= owner_nxt;
            last_q    <= last_nxt;
            extra_q   <= extra_nxt;
            tmr_q     <= tmr_nxt;
            err_q     <= err_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant_q;
        owner_nxt     = owner_q;
        last_nxt      = last_q;
        extra_nxt     = extra_q;
        tmr_nxt       = tmr_q;
        err_nxt       = err_q;
        frame_cnt_nxt = frame_cnt;
        unique case (state)
            S_IDLE: begin
                if (win_vld && sif.eng_idle) begin
                    grant_nxt = win_oh;
                    owner_nxt = win_idx;
                    extra_nxt = |(sif.req_extra & win_oh);
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tmr_nxt   = '0;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // Engine that never leaves idle still releases the owner, but is not counted as a frame.
                if (!sif.eng_idle) begin
                    state_nxt = S_WAIT_IDLE;
                end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tmr_nxt = tmr_q + TW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (sif.eng_idle) begin
                    frame_cnt_nxt = frame_cnt + 16'd1;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                grant_nxt = '0;
                extra_nxt = 1'b0;
                last_nxt  = owner_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign sif.grant              = grant_q;
    assign sif.done               = (state == S_DONE) ? grant_q : '0;
    assign sif.eng_start          = (state == S_LAUNCH);
    assign sif.eng_extra_at_start = extra_q;
    assign sif.busy               = (state != S_IDLE);
    assign sif.start_err          = err_q;
    assign sif.frame_count        = frame_cnt;

endmodule

// File: tb/tb_engine_scheduler.sv
// Bench for engine_scheduler: directed scenarios plus random traffic, all outputs compared each cycle
// against a job-level reference model driven by the same inputs.
module tb_engine_scheduler;
    import engine_sched_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    engine_scheduler_if #(.NUM_REQ(N)) sif();

    engine_scheduler #(.NUM_REQ(N), .START_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Reference model: one job at a time, described by its phase flags.
    bit          m_job, m_launched, m_seen_busy, m_fin, m_extra, m_err;
    int          m_owner, m_last, m_wait;
    logic [15:0] m_cnt;

    // Engine model and observation records.
    int         rem = 0, busy_len = 20;
    bit         stuck = 1'b0, rand_mode = 1'b0, prev_start = 1'b0;
    int         idle_rise_cyc, last_start_cyc, last_done_cyc, err_rise_cyc, done_pulses;
    logic [N-1:0] last_start_grant, last_done_val;
    logic       last_start_extra;
    bit         err_seen;
    logic [N-1:0] grant_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int i = 1; i <= N; i++) begin
            int k;
            k = (last + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            m_job = 0; m_fin = 0; m_launched = 0; m_seen_busy = 0;
            m_last = N - 1; m_err = 0; m_cnt = '0; m_extra = 0; m_owner = 0; m_wait = 0;
        end else if (m_job) begin
            if (m_fin) begin
                m_job = 0; m_fin = 0; m_last = m_owner; m_extra = 0;
            end else if (!m_launched) begin
                m_launched = 1; m_wait = 0; m_seen_busy = 0;
            end else if (!m_seen_busy) begin
                if (!sif.eng_idle) m_seen_busy = 1;
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin m_err = 1; m_fin = 1; end
                end
            end else if (sif.eng_idle) begin
                m_cnt = m_cnt + 16'd1;
                m_fin = 1;
            end
        end else if (sif.eng_idle) begin
            w = rr_pick(sif.req, m_last);
            if (w >= 0) begin
                m_job = 1; m_owner = w; m_extra = sif.req_extra[w]; m_launched = 0;
            end
        end
    endtask

    task automatic engine_step();
        bit new_idle;
        if (rst) begin
            rem = 0;
            sif.eng_idle = 1'b1;
        end else begin
            if (prev_start) begin
                if (stuck || (rand_mode && $urandom_range(0, 9) == 0)) rem = 0;
                else rem = busy_len;
            end else if (rem > 0) begin
                rem--;
            end
            new_idle = (rem == 0);
            if (new_idle && !sif.eng_idle) idle_rise_cyc = cyc;
            sif.eng_idle = new_idle;
        end
        prev_start = sif.eng_start;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        engine_step();
        if (sif.eng_start) begin
            last_start_cyc   = cyc;
            last_start_grant = sif.grant;
            last_start_extra = sif.eng_extra_at_start;
            grant_log.push_back(sif.grant);
        end
        if (sif.done != '0) begin
            done_pulses++;
            last_done_cyc = cyc;
            last_done_val = sif.done;
        end
        if (sif.start_err && !err_seen) begin
            err_seen     = 1'b1;
            err_rise_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        err_seen = 1'b0;
    endtask

    task automatic wait_start(input int lim);
        for (int i = 0; i < lim; i++) begin
            tick();
            if (sif.eng_start) return;
        end
        timeout_fail("wait_start");
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            tick();
            if (sif.done != '0) return;
        end
        timeout_fail("wait_done");
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : cmp
        logic [N-1:0] eg;
        if (chk_en) begin
            eg = m_job ? N'(1 << m_owner) : '0;
            check("grant",       sif.grant,              eg);
            check("done",        sif.done,               m_fin ? eg : '0);
            check("eng_start",   sif.eng_start,          m_job && !m_launched);
            check("eng_extra",   sif.eng_extra_at_start, m_job && m_extra);
            check("busy",        sif.busy,               m_job);
            check("start_err",   sif.start_err,          m_err);
            check("frame_count", sif.frame_count,        m_cnt);
            check("grant_onehot0",  $countones(sif.grant) <= 1, 1);
            check("done_in_grant",  |(sif.done & ~sif.grant),   0);
            check("start_not_busy", sif.eng_start & ~sif.eng_idle, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [N-1:0] exp_order [8];
        logic [N-1:0] r;
        int req_cyc, p0;

        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        done_pulses = 0;
        err_seen = 1'b0;
        sif.req = '0;
        sif.req_extra = '0;
        sif.eng_idle = 1'b1;
        rst = 1'b1;

        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        check("rst_grant",     sif.grant,       0);
        check("rst_done",      sif.done,        0);
        check("rst_eng_start", sif.eng_start,   0);
        check("rst_busy",      sif.busy,        0);
        check("rst_start_err", sif.start_err,   0);
        check("rst_frame_cnt", sif.frame_count, 0);
        rst = 1'b0;
        tick();

        // Single request with extra row.
        busy_len = 20;
        sif.req_extra = 4'b0001;
        sif.req = 4'b0001;
        req_cyc = cyc;
        wait_start(10);
        check("s1_grant",       last_start_grant, 4'b0001);
        check("s1_start_lat",   last_start_cyc - req_cyc, 1);
        check("s1_extra",       last_start_extra, 1);
        wait_done(60);
        sif.req = '0;
        sif.req_extra = '0;
        check("s1_done",        last_done_val, 4'b0001);
        check("s1_done_lat",    last_done_cyc - idle_rise_cyc, 1);
        tick();
        check("s1_frame_count", sif.frame_count, 1);

        // Fairness with all requesters held.
        do_reset();
        busy_len = 3;
        grant_log.delete();
        sif.req = 4'b1111;
        for (int j = 0; j < 8; j++) wait_done(40);
        sif.req = '0;
        tick();
        check("s2_jobs", grant_log.size(), 8);
        for (int j = 0; j < 8 && j < grant_log.size(); j++)
            check($sformatf("s2_order%0d", j), grant_log[j], exp_order[j]);
        check("s2_frame_count", sif.frame_count, 8);

        // Late request arriving mid-job.
        do_reset();
        busy_len = 10;
        sif.req = 4'b0100;
        wait_start(10);
        repeat (3) tick();
        sif.req = 4'b0110;
        wait_done(40);
        check("s3_first_done", last_done_val, 4'b0100);
        sif.req = 4'b0010;
        wait_start(10);
        check("s3_next_grant", last_start_grant, 4'b0010);
        wait_done(40);
        sif.req = '0;
        tick();

        // Engine never leaves idle.
        do_reset();
        stuck = 1'b1;
        sif.req = 4'b0001;
        wait_start(10);
        p0 = done_pulses;
        wait_done(20);
        sif.req = '0;
        repeat (6) tick();
        stuck = 1'b0;
        check("s4_done_pulses", done_pulses - p0, 1);
        check("s4_done",        last_done_val, 4'b0001);
        check("s4_err_lat",     err_rise_cyc - last_start_cyc, TMO + 1);
        check("s4_start_err",   sif.start_err, 1);
        check("s4_frame_count", sif.frame_count, 0);

        // Reset in the middle of a job.
        do_reset();
        busy_len = 20;
        sif.req = 4'b0100;
        wait_start(10);
        repeat (5) tick();
        p0 = done_pulses;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sif.req = '0;
        check("s5_grant",     sif.grant, 0);
        check("s5_busy",      sif.busy, 0);
        check("s5_done",      sif.done, 0);
        check("s5_eng_start", sif.eng_start, 0);
        check("s5_extra",     sif.eng_extra_at_start, 0);
        check("s5_frame_cnt", sif.frame_count, 0);
        tick();
        check("s5_no_done", done_pulses - p0, 0);
        sif.req = 4'b1111;
        wait_start(10);
        check("s5_first_grant", last_start_grant, 4'b0001);
        sif.req = 4'b0001;
        wait_done(40);
        sif.req = '0;
        tick();

        // Frame counter wrap from a preloaded value.
        do_reset();
        force dut.frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        tick();
        check("s6_preload", sif.frame_count, 16'hFFFF);
        busy_len = 2;
        sif.req = 4'b0001;
        wait_done(30);
        sif.req = '0;
        tick();
        check("s6_wrap", sif.frame_count, 16'h0000);

        // Random traffic, random engine timing, occasional stalls and resets.
        do_reset();
        rand_mode = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            r = sif.req;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[i] = 1'b1;
                end
            end
            sif.req = r;
            sif.req_extra = N'($urandom);
            busy_len = $urandom_range(1, 6);
            rst = ($urandom_range(0, 499) == 0);
        end
        rand_mode = 1'b0;
        rst = 1'b0;
        sif.req = '0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
